// File: rtl/morse_symbol_sequencer.sv
// Morse timing sequencer: unit sampling, dot/dash classification, character handshake.
// Optional MORSE_SEQ_ERR_EN enables err strobes and discards overlong characters.
module morse_symbol_sequencer #(
    parameter int TICK_DIV = 1,
    parameter int MAX_SYMS = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                din,
    input  logic                dec_ready,
    output logic                sym_valid,
    output logic [MAX_SYMS-1:0] code,
    output logic [2:0]          len,
    output logic                word_gap,
    output logic                err
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(MAX_SYMS + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MARK,
        S_SPACE
    } state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
    logic [2:0]          run_q, run_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [MAX_SYMS-1:0] acc_q, acc_d;
    logic                bad_q, bad_d;
    logic                seen_q, seen_d;
    logic                sym_valid_q, sym_valid_d;
    logic [MAX_SYMS-1:0] code_q, code_d;
    logic [2:0]          len_q, len_d;
    logic                word_gap_q, word_gap_d;
    logic                err_q, err_d;
    logic                tick;
    logic                complete;
    logic [2:0]          run_inc;

    always_comb begin
        tick_cnt_d  = tick_cnt_q;
        state_d     = state_q;
        run_d       = run_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        bad_d       = bad_q;
        seen_d      = seen_q;
        sym_valid_d = sym_valid_q;
        code_d      = code_q;
        len_d       = len_q;
        word_gap_d  = 1'b0;
        err_d       = 1'b0;
        complete    = 1'b0;

        tick = (tick_cnt_q == '0);
        if (tick_cnt_q == TW'(TICK_DIV - 1))
            tick_cnt_d = '0;
        else
            tick_cnt_d = tick_cnt_q + TW'(1);

        run_inc = (run_q == 3'd7) ? 3'd7 : run_q + 3'd1;

        if (tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (din) begin
                        state_d = S_MARK;
                        run_d   = 3'd1;
                    end
                end
                S_MARK: begin
                    if (din) begin
                        run_d = run_inc;
                    end else begin
                        state_d = S_SPACE;
                        run_d   = 3'd1;
                        if (cnt_q < CW'(MAX_SYMS)) begin
                            for (int i = 0; i < MAX_SYMS; i++)
                                if (cnt_q == CW'(i))
                                    acc_d[i] = (run_q >= 3'd3);
                            cnt_d = cnt_q + CW'(1);
                        end
`ifdef MORSE_SEQ_ERR_EN
                        else begin
                            err_d = ~bad_q;
                            bad_d = 1'b1;
                        end
`endif
                    end
                end
                S_SPACE: begin
                    if (din) begin
                        state_d = S_MARK;
                        run_d   = 3'd1;
                    end else begin
                        run_d = run_inc;
                        if (run_inc == 3'd3)
                            complete = 1'b1;
                        if (run_inc == 3'd7) begin
                            word_gap_d = seen_q;
                            seen_d     = 1'b0;
                            state_d    = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (sym_valid_q && dec_ready)
            sym_valid_d = 1'b0;

        // A completing character beats a same-edge accept.
        if (complete) begin
            acc_d = '0;
            cnt_d = '0;
            bad_d = 1'b0;
            if (!bad_q) begin
                seen_d = 1'b1;
                if (!sym_valid_q || dec_ready) begin
                    sym_valid_d = 1'b1;
                    code_d      = acc_q;
                    len_d       = 3'(cnt_q);
                end
`ifdef MORSE_SEQ_ERR_EN
                else begin
                    err_d = 1'b1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            run_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            bad_q       <= 1'b0;
            seen_q      <= 1'b0;
            sym_valid_q <= 1'b0;
            code_q      <= '0;
            len_q       <= '0;
            word_gap_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            run_q       <= run_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            bad_q       <= bad_d;
            seen_q      <= seen_d;
            sym_valid_q <= sym_valid_d;
            code_q      <= code_d;
            len_q       <= len_d;
            word_gap_q  <= word_gap_d;
            err_q       <= err_d;
        end
    end

    assign sym_valid = sym_valid_q;
    assign code      = code_q;
    assign len       = len_q;
    assign word_gap  = word_gap_q;
    assign err       = err_q;

endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// Directed bench for morse_symbol_sequencer: vector table plus a
// tick-divider/overlong sequence on a second instance.
module tb_morse_symbol_sequencer;

`ifdef MORSE_SEQ_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din, rdy;
    logic       sv, wg, er;
    logic [5:0] code;
    logic [2:0] len;

    logic       din1, rdy1;
    logic       sv1, wg1, er1;
    logic [5:0] code1;
    logic [2:0] len1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    morse_symbol_sequencer #(.TICK_DIV(1), .MAX_SYMS(6)) dut0 (
        .clk(clk), .reset(rst_n), .din(din), .dec_ready(rdy),
        .sym_valid(sv), .code(code), .len(len),
        .word_gap(wg), .err(er)
    );

    morse_symbol_sequencer #(.TICK_DIV(3), .MAX_SYMS(6)) dut1 (
        .clk(clk), .reset(rst_n), .din(din1), .dec_ready(rdy1),
        .sym_valid(sv1), .code(code1), .len(len1),
        .word_gap(wg1), .err(er1)
    );

    typedef struct {
        logic       din, rdy, rst, chk, sv;
        logic [2:0] len;
        logic [5:0] code;
        logic       wg, er;
    } vec_t;

    vec_t vq[$];

    task automatic x(input logic d, r, s);
        vec_t v;
        v = '{d, r, s, 1'b0, 1'b0, 3'd0, 6'd0, 1'b0, 1'b0};
        vq.push_back(v);
    endtask

    task automatic c(input logic d, r, s, e_sv,
                     input logic [2:0] e_len,
                     input logic [5:0] e_code,
                     input logic e_wg, e_er);
        vec_t v;
        v = '{d, r, s, 1'b1, e_sv, e_len, e_code, e_wg, e_er};
        vq.push_back(v);
    endtask

    int err_hi, sv_hi, wg_hi;
    logic [2:0] cap_len;
    logic [5:0] cap_code;

    task automatic run1(input logic d, input int n);
        repeat (n) begin
            din1 = d;
            @(posedge clk);
            #1;
            if (er1) err_hi++;
            if (wg1) wg_hi++;
            if (sv1) begin
                sv_hi++;
                cap_len  = len1;
                cap_code = code1;
            end
        end
    endtask

    task automatic chk1(input string nm, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        din   = 1'b0;
        rdy   = 1'b1;
        din1  = 1'b0;
        rdy1  = 1'b1;

        // reset with din held high: all outputs 0
        c(1, 1, 0, 0, 0, 0, 0, 0);
        c(1, 1, 0, 0, 0, 0, 0, 0);
        // S = 1,0,1,0,1 then letter gap
        c(1, 1, 1, 0, 0, 0, 0, 0);
        x(0, 1, 1); x(1, 1, 1); x(0, 1, 1); x(1, 1, 1);
        x(0, 1, 1);
        c(0, 1, 1, 0, 0, 0, 0, 0);
        c(0, 1, 1, 1, 3, 6'b000000, 0, 0);
        // O = three dashes
        c(1, 1, 1, 0, 0, 0, 0, 0);
        x(1, 1, 1); x(1, 1, 1); x(0, 1, 1);
        x(1, 1, 1); x(1, 1, 1); x(1, 1, 1); x(0, 1, 1);
        x(1, 1, 1); x(1, 1, 1); x(1, 1, 1);
        x(0, 1, 1);
        c(0, 1, 1, 0, 0, 0, 0, 0);
        c(0, 1, 1, 1, 3, 6'b000111, 0, 0);
        // S again, then word gap
        c(1, 1, 1, 0, 0, 0, 0, 0);
        x(0, 1, 1); x(1, 1, 1); x(0, 1, 1); x(1, 1, 1);
        x(0, 1, 1); x(0, 1, 1);
        c(0, 1, 1, 1, 3, 6'b000000, 0, 0);
        c(0, 1, 1, 0, 0, 0, 0, 0);
        x(0, 1, 1); x(0, 1, 1);
        c(0, 1, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++)
            c(0, 1, 1, 0, 0, 0, 0, 0);

        // T under backpressure, then E overruns it
        x(1, 0, 1); x(1, 0, 1); x(1, 0, 1);
        c(0, 0, 1, 0, 0, 0, 0, 0);
        c(0, 0, 1, 0, 0, 0, 0, 0);
        c(0, 0, 1, 1, 1, 6'b000001, 0, 0);
        c(1, 0, 1, 1, 1, 6'b000001, 0, 0);
        c(0, 0, 1, 1, 1, 6'b000001, 0, 0);
        c(0, 0, 1, 1, 1, 6'b000001, 0, 0);
        c(0, 0, 1, 1, 1, 6'b000001, 0, ERR_EN);
        c(0, 1, 1, 0, 0, 0, 0, 0);
        c(0, 0, 1, 0, 0, 0, 0, 0);
        c(0, 0, 1, 0, 0, 0, 0, 0);
        c(0, 0, 1, 0, 0, 0, 1, 0);
        c(0, 0, 1, 0, 0, 0, 0, 0);

        // reset mid-character, then E
        x(1, 1, 1); x(1, 1, 1); x(1, 1, 1); x(0, 1, 1);
        c(0, 1, 0, 0, 0, 0, 0, 0);
        c(1, 1, 1, 0, 0, 0, 0, 0);
        x(0, 1, 1); x(0, 1, 1);
        c(0, 1, 1, 1, 1, 6'b000000, 0, 0);
        c(0, 1, 1, 0, 0, 0, 0, 0);
        x(0, 1, 1); x(0, 1, 1);
        c(0, 1, 1, 0, 0, 0, 1, 0);

        // completion on the same edge as accept
        x(1, 0, 1); x(1, 0, 1); x(1, 0, 1);
        x(0, 0, 1); x(0, 0, 1);
        c(0, 0, 1, 1, 1, 6'b000001, 0, 0);
        x(1, 0, 1); x(0, 0, 1); x(0, 0, 1);
        c(0, 1, 1, 1, 1, 6'b000000, 0, 0);
        c(0, 1, 1, 0, 0, 0, 0, 0);

        foreach (vq[i]) begin
            rst_n = vq[i].rst;
            din   = vq[i].din;
            rdy   = vq[i].rdy;
            @(posedge clk);
            #1;
            if (vq[i].chk) begin
                total++;
                if (sv !== vq[i].sv || wg !== vq[i].wg ||
                    er !== vq[i].er ||
                    (vq[i].sv &&
                     (len !== vq[i].len || code !== vq[i].code))) begin
                    bad++;
                    $display("FAIL vec%0d: got sv=%b len=%0d code=%b wg=%b err=%b want sv=%b len=%0d code=%b wg=%b err=%b",
                             i, sv, len, code, wg, er, vq[i].sv,
                             vq[i].len, vq[i].code, vq[i].wg, vq[i].er);
                end
            end
        end

        // overlong character through the divide-by-3 instance
        rst_n  = 1'b1;
        err_hi = 0;
        sv_hi  = 0;
        wg_hi  = 0;
        cap_len  = '0;
        cap_code = '1;
        run1(1'b0, 6);
        for (int i = 0; i < 7; i++) begin
            run1(1'b1, 3);
            run1(1'b0, 3);
        end
        run1(1'b0, 36);
        chk1("overlong_err", err_hi, ERR_EN ? 1 : 0);
        chk1("overlong_valid", sv_hi, ERR_EN ? 0 : 1);
`ifndef MORSE_SEQ_ERR_EN
        chk1("overlong_len", int'(cap_len), 6);
        chk1("overlong_code", int'(cap_code), 0);
        chk1("overlong_word_gap", wg_hi, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/morse_symbol_sequencer.md
# morse_symbol_sequencer

Timing controller that sits between the raw keyed input `din` and the Morse character lookup. It samples `din` once per Morse time unit and measures mark and space run lengths. Each mark is classified as dot or dash. Elements are assembled into a character word, which is presented to the downstream lookup through a valid/ready handshake, with a separate word-gap strobe for inserting the ASCII space.

## Interface
- `TICK_DIV`, default 1: clock cycles per Morse unit; `din` is sampled on every tick. 1 means one unit per clock.
- `MAX_SYMS`, default 6: maximum number of elements per character.
- `clk  input  1`: system clock; all logic on the rising edge.
- `reset  input  1`: synchronous, active-low reset.
- `din  input  1`: keyed line; 1 = tone (mark), 0 = silence (space).
- `dec_ready  input  1`: lookup accepts the pending character.
- `sym_valid  output  1`: a character is pending on `code`/`len`.
- `code  output  MAX_SYMS`: `code[i]` is element i in send order; 1 = dash, 0 = dot; bits at or above `len` are 0.
- `len  output  3`: element count, 1..MAX_SYMS.
- `word_gap  output  1`: 1-cycle strobe when a word gap is detected.
- `err  output  1`: 1-cycle strobe for overrun or an overlong character (see Configuration).

## Operation
- **Tick generator.** Modulo-`TICK_DIV` counter. The tick is asserted on the cycle where the count is 0. With `TICK_DIV`=1 the tick is always high. The counter clears on reset.
- **States.** IDLE (reset state), MARK and SPACE. All transitions are evaluated only on a tick.
- **IDLE.** `din`=0 is ignored. `din`=1 moves to MARK with `run`=1.
- **MARK.** `din`=1 gives `run`++, saturating at 7. `din`=0 commits the element and moves to SPACE with `run`=1.
  - Element is a dot if `run` ≤ 2, a dash if `run` ≥ 3.
  - The element is written to `code[cnt]` and `cnt`++.
- **SPACE.** `din`=1 returns to MARK with `run`=1; this was an intra-character gap. `din`=0 gives `run`++, saturating at 7.
  - When `run` reaches 3 (letter gap), the character completes: the assembled `code`/`cnt` goes to the output register, `cnt` clears, and the state stays SPACE.
  - When `run` reaches 7 (word gap), `word_gap` pulses once. It pulses only if at least one character completed since the last word gap. The state then moves to IDLE.
- **Run counter.** 3-bit `run`, saturating at 7. `cnt` is wide enough for MAX_SYMS+1.
- **Handshake.**
  - `sym_valid`, `code` and `len` are held stable until a clock edge where `sym_valid` and `dec_ready` are both high.
  - After that accept, `sym_valid` is 0 on the next cycle, unless a new character completes on the same edge. In that case the new character loads and `sym_valid` stays 1.
- **Overrun.** A character that completes while `sym_valid`=1 and `dec_ready`=0 is dropped. The pending character is kept and `err` pulses.
- **Overlong character.** A character with more than MAX_SYMS elements is handled as described under Configuration.
- **Reset mid-operation.** Any partial character, pending output and tick phase are discarded. The block returns to IDLE.

## Timing
- **Reset values.** `sym_valid`=0, `code`=0, `len`=0, `word_gap`=0, `err`=0. Internally: state IDLE, `run`=0, `cnt`=0, tick counter 0.
- **Character latency.** `sym_valid` rises on the clock after the tick that samples the 3rd consecutive space.
- **Word-gap latency.** `word_gap` is high for exactly one clock after the tick that samples the 7th consecutive space.
- **First sample.** The first tick after reset release occurs on the first cycle with `reset`=1.
- **Simultaneous events.** Character completion plus accept: the new character wins and there is no `err`. A `word_gap` strobe coinciding with any handshake event is independent of it.
- **Strobe width.** `err` and `word_gap` are never wider than one clock, regardless of `TICK_DIV`.

## Configuration
- **Macro:** `MORSE_SEQ_ERR_EN`.
- **Defined:**
  - `err` is driven as specified.
  - An element beyond MAX_SYMS pulses `err` once and marks the character bad.
  - The bad character is discarded at its letter gap, so no `sym_valid` is raised for it.
- **Undefined:**
  - `err` is tied to 0.
  - Elements beyond MAX_SYMS are ignored: the character is truncated to its first MAX_SYMS elements and emitted with `len`=MAX_SYMS.
  - An overrun silently drops the new character.

## Test plan
- **S character.** `TICK_DIV`=1, `dec_ready`=1; `din` = 1,0,1,0,1,0,0,0. Expect `sym_valid` for one cycle with `len`=3, `code`=000000, on the clock after the 8th sample.
- **SOS + word gap.** Apply the SOS test stream: S, letter gap, O, letter gap, S, then 7 zeros. Expect:
  - three characters: (3, 000000), (3, 000111), (3, 000000);
  - one `word_gap` pulse, 7 samples after the last mark ends;
  - a further 10 zeros produce no further strobes.
- **Backpressure.** `dec_ready`=0; send T (1,1,1,0,0,0). Expect `sym_valid`=1, `len`=1, `code`=000001, held stable. Then raise `dec_ready` for one cycle: `sym_valid` drops on the next clock.
- **Overrun.** With T pending and `dec_ready`=0, send E (1,0,0,0). Expect:
  - `err` pulses with the macro defined, stays 0 without it;
  - `code`/`len` still show T;
  - after accept, E is not presented.
- **Overlong and tick divider.** `TICK_DIV`=3, MAX_SYMS=6; send 7 dots, each dot and gap held 3 clocks. Expect:
  - with `MORSE_SEQ_ERR_EN`: one `err` pulse and no `sym_valid`;
  - without it: `len`=6, `code`=000000.
- **Reset mid-character.** Send 1,1,1,0, then drive `reset`=0 for 1 clock, then send 1,0,0,0. Expect exactly one character: `len`=1, `code`=000000 (E). All outputs must be 0 during reset.
